dmem_responder: RTL and testbench
=================================

# dmem_responder

Single-port data-memory responder on the core's data interface (req/gnt/rvalid). Answers requests from the load/store unit, aligns byte/halfword/word accesses to lanes, and returns right-justified read data after a configurable latency. It replaces the bench-side memory model and serves as the on-chip data RAM.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- RD_LATENCY, 1: cycles from read grant to rvalid; legal range 1..4.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- data_req_i  in  1  request valid; addr, we, be and wdata are valid while high.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  4  size code, right-aligned: 0001 byte, 0011 half, 1111 word.
- data_wdata_i  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- stall_i  in  1  backpressure from the arbiter or bench; blocks grant.
- data_gnt_o  out  1  request accepted this cycle (combinational).
- data_rvalid_o  out  1  load response valid, one-cycle pulse.
- data_rdata_o  out  32  load data, right-justified and zero-extended.
- data_err_o  out  1  qualifies data_rvalid_o; response is an error.
- store_err_o  out  1  one-cycle pulse: a granted store was rejected.

## Operation
- Decode: size comes from be. Any other be value is illegal.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
- Range: legal addresses satisfy BASE_ADDR <= addr < BASE_ADDR+4*DEPTH. Word index = (addr-BASE_ADDR)>>2.
- Error: illegal be, misaligned, or out of range. An errored request is still granted, but memory is neither read nor written.
- Lane mapping: effective lane mask = be << addr[1:0]. Write data is shifted left by 8*addr[1:0]. Only masked lanes are written.
- Read return: word >> 8*addr[1:0], then masked to the size (upper bits zero). The requester performs sign extension.
- Grant: data_gnt_o = data_req_i & !stall_i & !busy & rst_ni.
- Read pipeline: a shift register of depth RD_LATENCY carries {valid, err, offset, size}. The memory word is read at grant and is pipelined or held until return.
- Busy (read grant only): busy is high in cycles T+1 .. T+RD_LATENCY-1, so at most one load is outstanding. Grants do not set busy for stores.
- Store completion is implied by grant; stores never produce rvalid.
- Errors: a load error returns rvalid=1, err=1, rdata=0. A store error pulses store_err_o.
- The responder has no flush input. A response owed for a granted load is always delivered.

## Timing
- Reset: while rst_ni=0 at a clock edge, the pipeline, busy and store_err_o are cleared. data_gnt_o is forced to 0 during reset.
  - All outputs are 0 in the cycle after reset.
  - Memory contents are not reset.
- Reset mid-operation drops any pending load response; no rvalid is issued for it.
- Store granted in cycle T: memory is updated at the end of T. store_err_o (if any) is high in T+1.
- Load granted in cycle T: rvalid/rdata/err are high in T+RD_LATENCY for exactly one cycle.
- A new grant is allowed in the rvalid cycle, so the back-to-back load throughput is one load per RD_LATENCY cycles.
- Read-after-write: a store granted in T followed by a load granted in T+1 returns the new data.
- stall_i only gates grant. It never delays an already-granted response.
- When data_req_i=0, data_gnt_o=0 regardless of state.
- The requester holds req and its fields stable until grant. The responder samples them only in the grant cycle.
- data_rdata_o is 0 whenever data_rvalid_o=0.

## Test plan
- RD_LATENCY=1, BASE=0:
  - Store SW 0xDEADBEEF at addr 0x10 -> gnt in the same cycle.
  - Load LW at 0x10 -> rvalid one cycle after gnt, rdata=0xDEADBEEF, err=0.
- Byte/half lanes: after SW 0xDEADBEEF at 0x10:
  - SB 0x55 at 0x12 -> word reads 0xDE55BEEF.
  - Load be=0001 at 0x13 -> rdata=0x000000DE.
  - Load be=0011 at 0x12 -> rdata=0x0000DE55.
- Errors:
  - Load be=1111 at 0x12 -> rvalid=1, err=1, rdata=0.
  - SH at 0x11 -> store_err_o pulses in T+1 and the word is unchanged.
  - Load at 4*DEPTH -> err=1.
  - be=0101 -> err.
- RD_LATENCY=3:
  - Two back-to-back loads -> second gnt withheld for 2 cycles, granted in the first rvalid cycle.
  - rvalid pulses arrive at T+3 and T+6.
- stall_i held high for 5 cycles with req=1 -> no gnt. Grant occurs in the cycle stall_i drops, and the request is not duplicated.
- Load granted, then rst_ni low in T+1 with RD_LATENCY=2 -> no rvalid is ever issued. After reset, all outputs are 0 and the next load is granted normally.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data RAM on the req/gnt/rvalid interface.
// It accepts byte, half and word accesses and returns load data after RD_LATENCY cycles.
module dmem_responder #(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          RD_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic        stall_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        store_err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);
    localparam logic [RD_LATENCY-1:0] BUSY_MASK = {RD_LATENCY{1'b1}} >> 1;

    logic [31:0]           r_mem [DEPTH];
    logic [RD_LATENCY-1:0] r_vld;
    logic [31:0]           r_word;
    logic                  r_err;
    logic [1:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_serr;

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_size;
    logic          w_bad_be;
    logic          w_mis;
    logic          w_oor;
    logic          w_err;
    logic          w_busy;
    logic          w_ld;
    logic          w_st;
    logic [3:0]    w_lane;
    logic [31:0]   w_wsh;
    logic [31:0]   w_rsh;
    logic [31:0]   w_rmask;

    always_comb begin
        w_size   = (data_be_i == 4'b1111) ? 2'd2 : (data_be_i == 4'b0011) ? 2'd1 : 2'd0;
        w_bad_be = !(data_be_i inside {4'b0001, 4'b0011, 4'b1111});
        w_mis    = (w_size == 2'd1 && data_addr_i[0]) || (w_size == 2'd2 && data_addr_i[1:0] != 2'b00);
        w_off    = data_addr_i - BASE_ADDR;
        w_oor    = (data_addr_i < BASE_ADDR) || (w_off >= SPAN);
        w_idx    = AW'(w_off >> 2);
        w_err    = w_bad_be || w_mis || w_oor;
        // only the first RD_LATENCY-1 stages block; the final stage is the rvalid cycle
        w_busy   = |(r_vld & BUSY_MASK);
        data_gnt_o = data_req_i && !stall_i && !w_busy && rst_ni;
        w_ld     = data_gnt_o && !data_we_i;
        w_st     = data_gnt_o && data_we_i && !w_err;
        w_lane   = data_be_i << data_addr_i[1:0];
        w_wsh    = data_wdata_i << {data_addr_i[1:0], 3'b000};
        w_rsh    = r_word >> {r_off, 3'b000};
        w_rmask  = (r_size == 2'd2) ? 32'hFFFF_FFFF : (r_size == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF;
        data_rvalid_o = r_vld[RD_LATENCY-1];
        data_err_o    = data_rvalid_o && r_err;
        data_rdata_o  = (data_rvalid_o && !r_err) ? (w_rsh & w_rmask) : 32'h0;
        store_err_o   = r_serr;
    end

    // memory and load payload are deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (w_st)
            for (int b = 0; b < 4; b++)
                if (w_lane[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
        if (w_ld && !w_err) r_word <= r_mem[w_idx];
        if (w_ld) begin
            r_err  <= w_err;
            r_off  <= data_addr_i[1:0];
            r_size <= w_size;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vld  <= '0;
            r_serr <= 1'b0;
        end else begin
            r_vld  <= (r_vld << 1) | RD_LATENCY'(w_ld);
            r_serr <= data_gnt_o && data_we_i && w_err;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of three responders with RD_LATENCY 1, 2 and 3.
module tb_dmem_responder;
    logic        clk = 0;
    logic        rst   [3];
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        stall [3];
    logic        gnt   [3];
    logic        rvalid[3];
    logic [31:0] rdata [3];
    logic        err   [3];
    logic        serr  [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rv_cnt [3];
    int rvc [3][8];
    logic [31:0] rvd [3][8];
    logic rve [3][8];
    int se_cnt [3];
    int se_cyc [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h0), .RD_LATENCY(g + 1)) u_dut (
            .clk_i(clk), .rst_ni(rst[g]), .data_req_i(req[g]), .data_addr_i(addr[g]),
            .data_we_i(we[g]), .data_be_i(be[g]), .data_wdata_i(wdata[g]), .stall_i(stall[g]),
            .data_gnt_o(gnt[g]), .data_rvalid_o(rvalid[g]), .data_rdata_o(rdata[g]),
            .data_err_o(err[g]), .store_err_o(serr[g])
        );
    end

    always @(negedge clk)
        for (int d = 0; d < 3; d++) begin
            if (rvalid[d] === 1'b1) begin
                rvc[d][rv_cnt[d] % 8] = cyc;
                rvd[d][rv_cnt[d] % 8] = rdata[d];
                rve[d][rv_cnt[d] % 8] = err[d];
                rv_cnt[d]++;
            end
            if (serr[d] === 1'b1) begin
                se_cyc[d] = cyc;
                se_cnt[d]++;
            end
        end

    task automatic xfer(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] wd, output int st, output int gc);
        gc = -1;
        @(negedge clk);
        req[d] = 1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd; st = cyc;
        for (int n = 0; n < 20 && gc < 0; n++) begin
            #1;
            if (gnt[d] === 1'b1) gc = cyc;
            else @(negedge clk);
        end
        if (gc < 0) begin
            checks++; errors++;
            $display("FAIL gnt_timeout d=%0d actual=no grant required=grant", d);
        end
        @(negedge clk);
        req[d] = 0;
    endtask

    task automatic ld(input int d, input logic [3:0] b, input logic [31:0] a, output logic [31:0] data,
                      output logic e, output int gc, output int rc, output int nrv);
        int n0, st, ix;
        n0 = rv_cnt[d];
        xfer(d, 1'b0, b, a, 32'h0, st, gc);
        repeat (6) @(negedge clk);
        #2;
        nrv = rv_cnt[d] - n0;
        ix = (rv_cnt[d] + 7) % 8;
        data = rvd[d][ix]; e = rve[d][ix]; rc = rvc[d][ix];
    endtask

    task automatic sto(input int d, input logic [3:0] b, input logic [31:0] a, input logic [31:0] wd,
                       output int st, output int gc);
        xfer(d, 1'b1, b, a, wd, st, gc);
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 0; req[d] = 0; we[d] = 0; be[d] = 0; addr[d] = 0; wdata[d] = 0; stall[d] = 0;
            rv_cnt[d] = 0; se_cnt[d] = 0; se_cyc[d] = -1;
        end
        repeat (3) @(negedge clk);
        req[0] = 1; be[0] = 4'hF;
        #1;
        checks++;
        if (gnt[0] !== 1'b0) begin errors++; $display("FAIL gnt_in_reset actual=%b required=0", gnt[0]); end
        req[0] = 0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({gnt[d], rvalid[d], rdata[d], err[d], serr[d]} !== 36'h0) begin
                errors++;
                $display("FAIL reset_outputs d=%0d actual=%b%b%h%b%b required=0", d, gnt[d], rvalid[d], rdata[d], err[d], serr[d]);
            end
        end
    endtask

    task automatic test_word;
        int st, gc, rc, n; logic [31:0] v; logic e;
        sto(0, 4'hF, 32'h10, 32'hDEAD_BEEF, st, gc);
        checks++;
        if (gc !== st) begin errors++; $display("FAIL sw_gnt_cycle actual=%0d required=%0d", gc, st); end
        ld(0, 4'hF, 32'h10, v, e, gc, rc, n);
        checks++;
        if (n !== 1 || rc !== gc + 1) begin errors++; $display("FAIL lw_latency actual=n%0d@%0d required=n1@%0d", n, rc, gc + 1); end
        checks++;
        if ({v, e} !== {32'hDEAD_BEEF, 1'b0}) begin errors++; $display("FAIL lw_data actual=%h/%b required=deadbeef/0", v, e); end
    endtask

    task automatic test_lanes;
        int st, gc, rc, n, n0; logic [31:0] v; logic e;
        n0 = rv_cnt[0];
        sto(0, 4'b0001, 32'h12, 32'hFFFF_FF55, st, gc);
        checks++;
        if (rv_cnt[0] !== n0) begin errors++; $display("FAIL store_no_rvalid actual=%0d required=0", rv_cnt[0] - n0); end
        ld(0, 4'hF, 32'h10, v, e, gc, rc, n);
        checks++;
        if (v !== 32'hDE55_BEEF) begin errors++; $display("FAIL sb_word actual=%h required=de55beef", v); end
        ld(0, 4'b0001, 32'h13, v, e, gc, rc, n);
        checks++;
        if (v !== 32'h0000_00DE) begin errors++; $display("FAIL lb_13 actual=%h required=000000de", v); end
        ld(0, 4'b0011, 32'h12, v, e, gc, rc, n);
        checks++;
        if (v !== 32'h0000_DE55) begin errors++; $display("FAIL lh_12 actual=%h required=0000de55", v); end
        ld(0, 4'b0001, 32'h11, v, e, gc, rc, n);
        checks++;
        if (v !== 32'h0000_00BE) begin errors++; $display("FAIL lb_11 actual=%h required=000000be", v); end
    endtask

    task automatic test_errors;
        int st, gc, rc, n, s0; logic [31:0] v; logic e;
        ld(0, 4'hF, 32'h12, v, e, gc, rc, n);
        checks++;
        if ({n, v, e} !== {32'd1, 32'h0, 1'b1}) begin errors++; $display("FAIL lw_misaligned actual=n%0d %h/%b required=n1 0/1", n, v, e); end
        s0 = se_cnt[0];
        sto(0, 4'b0011, 32'h11, 32'h0000_1234, st, gc);
        checks++;
        if (se_cnt[0] !== s0 + 1 || se_cyc[0] !== gc + 1) begin
            errors++; $display("FAIL sh_store_err actual=n%0d@%0d required=n1@%0d", se_cnt[0] - s0, se_cyc[0], gc + 1);
        end
        ld(0, 4'hF, 32'h10, v, e, gc, rc, n);
        checks++;
        if ({v, e} !== {32'hDE55_BEEF, 1'b0}) begin errors++; $display("FAIL sh_err_unchanged actual=%h/%b required=de55beef/0", v, e); end
        ld(0, 4'hF, 32'h100, v, e, gc, rc, n);
        checks++;
        if ({n, v, e} !== {32'd1, 32'h0, 1'b1}) begin errors++; $display("FAIL lw_range actual=n%0d %h/%b required=n1 0/1", n, v, e); end
        ld(0, 4'hF, 32'hFC, v, e, gc, rc, n);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL lw_last_word_err actual=%b required=0", e); end
        ld(0, 4'b0101, 32'h10, v, e, gc, rc, n);
        checks++;
        if ({v, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL bad_be actual=%h/%b required=0/1", v, e); end
        s0 = se_cnt[0];
        sto(0, 4'hF, 32'h100, 32'h1, st, gc);
        checks++;
        if (se_cnt[0] !== s0 + 1) begin errors++; $display("FAIL sw_range_err actual=%0d required=1", se_cnt[0] - s0); end
    endtask

    task automatic test_back_to_back;
        int st, gc, t1, t2, n0, i0, i1;
        sto(2, 4'hF, 32'h20, 32'h1122_3344, st, gc);
        sto(2, 4'hF, 32'h24, 32'h5566_7788, st, gc);
        @(negedge clk);
        n0 = rv_cnt[2];
        req[2] = 1; we[2] = 0; be[2] = 4'hF; addr[2] = 32'h20;
        #1;
        t1 = (gnt[2] === 1'b1) ? cyc : -1;
        @(negedge clk);
        addr[2] = 32'h24; t2 = -1;
        for (int n = 0; n < 10 && t2 < 0; n++) begin
            #1;
            if (gnt[2] === 1'b1) t2 = cyc;
            else @(negedge clk);
        end
        @(negedge clk);
        req[2] = 0;
        repeat (8) @(negedge clk);
        #2;
        i0 = n0 % 8; i1 = (n0 + 1) % 8;
        checks++;
        if (t1 < 0 || t2 !== t1 + 3) begin errors++; $display("FAIL b2b_second_gnt actual=%0d required=%0d", t2, t1 + 3); end
        checks++;
        if (rv_cnt[2] - n0 !== 2) begin errors++; $display("FAIL b2b_rvalid_count actual=%0d required=2", rv_cnt[2] - n0); end
        checks++;
        if (rvc[2][i0] !== t1 + 3 || rvc[2][i1] !== t1 + 6) begin
            errors++; $display("FAIL b2b_rvalid_cycles actual=%0d,%0d required=%0d,%0d", rvc[2][i0], rvc[2][i1], t1 + 3, t1 + 6);
        end
        checks++;
        if ({rvd[2][i0], rvd[2][i1]} !== {32'h1122_3344, 32'h5566_7788}) begin
            errors++; $display("FAIL b2b_data actual=%h,%h required=11223344,55667788", rvd[2][i0], rvd[2][i1]);
        end
    endtask

    task automatic test_stall;
        int n0; logic g;
        @(negedge clk);
        n0 = rv_cnt[0]; g = 0;
        stall[0] = 1; req[0] = 1; we[0] = 0; be[0] = 4'hF; addr[0] = 32'h10;
        for (int n = 0; n < 5; n++) begin
            #1;
            g = g | (gnt[0] !== 1'b0);
            @(negedge clk);
        end
        checks++;
        if (g !== 1'b0) begin errors++; $display("FAIL stall_gnt actual=1 required=0"); end
        stall[0] = 0;
        #1;
        checks++;
        if (gnt[0] !== 1'b1) begin errors++; $display("FAIL stall_release_gnt actual=%b required=1", gnt[0]); end
        @(negedge clk);
        req[0] = 0;
        repeat (5) @(negedge clk);
        #2;
        checks++;
        if (rv_cnt[0] - n0 !== 1 || rvd[0][n0 % 8] !== 32'hDE55_BEEF) begin
            errors++; $display("FAIL stall_single_resp actual=n%0d %h required=n1 de55beef", rv_cnt[0] - n0, rvd[0][n0 % 8]);
        end
    endtask

    task automatic test_reset_mid;
        int st, gc, rc, n, n0; logic [31:0] v; logic e, g;
        sto(1, 4'hF, 32'h30, 32'hCAFE_F00D, st, gc);
        @(negedge clk);
        n0 = rv_cnt[1];
        req[1] = 1; we[1] = 0; be[1] = 4'hF; addr[1] = 32'h30;
        #1;
        g = gnt[1];
        @(negedge clk);
        req[1] = 0; rst[1] = 0;
        @(negedge clk);
        rst[1] = 1;
        @(negedge clk);
        checks++;
        if ({gnt[1], rvalid[1], rdata[1], err[1], serr[1]} !== 36'h0) begin
            errors++; $display("FAIL post_reset_outputs actual=%b%b%h%b%b required=0", gnt[1], rvalid[1], rdata[1], err[1], serr[1]);
        end
        repeat (4) @(negedge clk);
        #2;
        checks++;
        if (g !== 1'b1 || rv_cnt[1] !== n0) begin errors++; $display("FAIL reset_drop actual=gnt%b n%0d required=gnt1 n0", g, rv_cnt[1] - n0); end
        ld(1, 4'hF, 32'h30, v, e, gc, rc, n);
        checks++;
        if (n !== 1 || rc !== gc + 2 || {v, e} !== {32'hCAFE_F00D, 1'b0}) begin
            errors++; $display("FAIL post_reset_load actual=n%0d@%0d %h/%b required=n1@%0d cafef00d/0", n, rc, v, e, gc + 2);
        end
    endtask

    initial begin
        test_reset;
        test_word;
        test_lanes;
        test_errors;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
